// File: rtl/serial_eq_controller.sv
// Serial equality controller: walks two latched WIDTH-bit operands through an
// external 2-bit comparator, one slice per clock, and registers the verdict.
module serial_eq_controller #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       cmp_a,
    output logic [1:0]       cmp_b,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic             eq
);

    localparam int unsigned    NSLICE   = WIDTH / 2;
    localparam int unsigned    IDXW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              acc_q, acc_d;
    logic              eq_q, eq_d;
    logic [WIDTH-1:0]  a_sh, b_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            eq_q    <= eq_d;
        end
    end

    // Slice selection by shifting avoids an index-width mismatch on the part select.
    assign a_sh = a_q >> {idx_q, 1'b0};
    assign b_sh = b_q >> {idx_q, 1'b0};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        eq_d    = eq_q;
        busy    = 1'b0;
        done    = 1'b0;
        cmp_a   = '0;
        cmp_b   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    acc_d   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                cmp_a = a_sh[1:0];
                cmp_b = b_sh[1:0];
                acc_d = acc_q & cmp_eq;
                if (!cmp_eq && EARLY_EXIT) begin
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == LAST_IDX) begin
                    eq_d    = acc_q & cmp_eq;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign eq = eq_q;

endmodule

// File: tb/tb_serial_eq_controller.sv
// Bench for serial_eq_controller: two instances (early exit on/off) sharing operands,
// each with its own 2-bit comparator; a scoreboard checks slices, latency and verdicts.
module tb_serial_eq_controller;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       eq;
        int         me;
        int         mf;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       eq;
        int         m;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_e, start_f;
    logic [7:0] a, b;
    logic [1:0] cmp_a_e, cmp_b_e, cmp_a_f, cmp_b_f;
    logic       cmp_eq_e, cmp_eq_f;
    logic       busy_e, done_e, eq_e, busy_f, done_f, eq_f;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_e[$];
    exp_t sb_f[$];
    int   run_cnt[2];
    bit   last_eq[2];
    vec_t vt[8];

    always #5 clk = ~clk;

    assign cmp_eq_e = (cmp_a_e == cmp_b_e);
    assign cmp_eq_f = (cmp_a_f == cmp_b_f);

    serial_eq_controller #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .reset(reset), .start(start_e), .a(a), .b(b),
        .cmp_a(cmp_a_e), .cmp_b(cmp_b_e), .cmp_eq(cmp_eq_e),
        .busy(busy_e), .done(done_e), .eq(eq_e)
    );

    serial_eq_controller #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .a(a), .b(b),
        .cmp_a(cmp_a_f), .cmp_b(cmp_b_f), .cmp_eq(cmp_eq_f),
        .busy(busy_f), .done(done_f), .eq(eq_f)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int d, input logic bz, input logic dn, input logic ev,
                       input logic [1:0] ca, input logic [1:0] cb);
        exp_t x;
        bit   have;
        have = (d == 0) ? (sb_e.size() > 0) : (sb_f.size() > 0);
        if (have) x = (d == 0) ? sb_e[0] : sb_f[0];
        if (bz) begin
            chk("run_without_start", int'(have), 1);
            if (have && run_cnt[d] < 4) begin
                chk("cmp_a_slice", int'(ca), int'((x.a >> (2 * run_cnt[d])) & 8'h03));
                chk("cmp_b_slice", int'(cb), int'((x.b >> (2 * run_cnt[d])) & 8'h03));
            end
            run_cnt[d]++;
        end else begin
            chk("cmp_idle_zero", int'({ca, cb}), 0);
        end
        if (dn) begin
            chk("done_not_busy", int'(bz), 0);
            chk("spurious_done", int'(have), 1);
            if (have) begin
                chk("verdict", int'(ev), int'(x.eq));
                chk("run_cycles", run_cnt[d], x.m);
                last_eq[d] = x.eq;
                if (d == 0) void'(sb_e.pop_front());
                else        void'(sb_f.pop_front());
            end
            run_cnt[d] = 0;
        end else begin
            chk("eq_hold", int'(ev), int'(last_eq[d]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon(0, busy_e, done_e, eq_e, cmp_a_e, cmp_b_e);
        mon(1, busy_f, done_f, eq_f, cmp_a_f, cmp_b_f);
    endtask

    task automatic push(input logic [7:0] av, input logic [7:0] bv, input logic ev,
                        input int me, input int mf);
        sb_e.push_back('{a: av, b: bv, eq: ev, m: me});
        sb_f.push_back('{a: av, b: bv, eq: ev, m: mf});
    endtask

    task automatic run_both(input vec_t v);
        tick();
        a = v.a; b = v.b; start_e = 1'b1; start_f = 1'b1;
        push(v.a, v.b, v.eq, v.me, v.mf);
        tick();
        start_e = 1'b0; start_f = 1'b0;
        for (int n = 0; n < 20 && (sb_e.size() + sb_f.size()) > 0; n++) tick();
        chk("done_timeout", sb_e.size() + sb_f.size(), 0);
        tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", int'({busy_e, busy_f}), 0);
        chk("rst_done", int'({done_e, done_f}), 0);
        chk("rst_eq", int'({eq_e, eq_f}), 0);
        chk("rst_cmp", int'({cmp_a_e, cmp_b_e, cmp_a_f, cmp_b_f}), 0);
    endtask

    initial begin
        vt[0] = '{a: 8'hA5, b: 8'hA5, eq: 1'b1, me: 4, mf: 4};
        vt[1] = '{a: 8'hA5, b: 8'hA4, eq: 1'b0, me: 1, mf: 4};
        vt[2] = '{a: 8'h00, b: 8'hC0, eq: 1'b0, me: 4, mf: 4};
        vt[3] = '{a: 8'h3C, b: 8'h3C, eq: 1'b1, me: 4, mf: 4};
        vt[4] = '{a: 8'hFF, b: 8'h00, eq: 1'b0, me: 1, mf: 4};
        vt[5] = '{a: 8'h12, b: 8'h1E, eq: 1'b0, me: 2, mf: 4};
        vt[6] = '{a: 8'h00, b: 8'h00, eq: 1'b1, me: 4, mf: 4};
        vt[7] = '{a: 8'h30, b: 8'h00, eq: 1'b0, me: 3, mf: 4};
        run_cnt[0] = 0; run_cnt[1] = 0;
        last_eq[0] = 1'b0; last_eq[1] = 1'b0;

        reset = 1'b1; start_e = 1'b0; start_f = 1'b0; a = '0; b = '0;
        #3;
        chk_reset_outputs();
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_both(vt[i]);

        // Previous verdict is 1; extra starts and operand changes mid-run must be ignored.
        run_both(vt[0]);
        tick();
        a = 8'h00; b = 8'hC0; start_e = 1'b1; start_f = 1'b1;
        push(8'h00, 8'hC0, 1'b0, 4, 4);
        tick();
        a = 8'hFF; b = 8'h00; start_e = 1'b1; start_f = 1'b1;
        tick();
        start_e = 1'b0; start_f = 1'b0;
        tick();
        start_e = 1'b1; start_f = 1'b1;
        tick();
        start_e = 1'b0; start_f = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        chk("ignored_start_queue", sb_e.size() + sb_f.size(), 0);

        // Start held high: early-exit instance turns around every 3 cycles, full every 6.
        tick();
        a = 8'hA5; b = 8'hA4; start_e = 1'b1; start_f = 1'b1;
        for (int k = 0; k < 6; k++) sb_e.push_back('{a: 8'hA5, b: 8'hA4, eq: 1'b0, m: 1});
        for (int k = 0; k < 3; k++) sb_f.push_back('{a: 8'hA5, b: 8'hA4, eq: 1'b0, m: 4});
        for (int n = 0; n < 18; n++) tick();
        start_e = 1'b0; start_f = 1'b0;
        chk("held_left_e", sb_e.size(), 0);
        chk("held_left_f", sb_f.size(), 0);
        for (int n = 0; n < 4; n++) tick();

        // Establish eq=1, then reset asynchronously in the 2nd run cycle.
        run_both(vt[6]);
        tick();
        a = 8'hA5; b = 8'hA5; start_e = 1'b1; start_f = 1'b1;
        push(8'hA5, 8'hA5, 1'b1, 4, 4);
        tick();
        start_e = 1'b0; start_f = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs();
        sb_e.delete(); sb_f.delete();
        run_cnt[0] = 0; run_cnt[1] = 0;
        last_eq[0] = 1'b0; last_eq[1] = 1'b0;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        run_both(vt[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_eq_controller.md
Name: serial_eq_controller

Overview:
- Sequences a shared external 2-bit equality comparator (inputs a, b; output eq) to compare two WIDTH-bit words, one 2-bit slice per clock, LSB slice first.
- Latches operands on start, steps the comparator's inputs through every slice, accumulates the per-slice results and reports one registered equality verdict with a done pulse.
- Lets wide equality checks reuse a single small comparator instance.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 2. NSLICE = WIDTH/2.
- EARLY_EXIT, 1, 1 = terminate on the first mismatching slice; 0 = always visit all NSLICE slices.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on start acceptance.
- b  input  WIDTH  operand B; sampled on start acceptance.
- cmp_a  output  2  slice of latched A driven to the comparator's a input.
- cmp_b  output  2  slice of latched B driven to the comparator's b input.
- cmp_eq  input  1  comparator eq output (combinational, same cycle).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the verdict is final.
- eq  output  1  registered verdict; 1 = a equal to b.

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. While reset is high, FSM = IDLE, slice index = 0, operand registers = 0. Outputs during reset: busy = 0, done = 0, eq = 0, cmp_a = 2'b00, cmp_b = 2'b00.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at a rising edge latches a and b, sets index = 0, sets accumulator = 1, and moves to RUN.
  - start = 0: stay in IDLE.
- RUN:
  - cmp_a = A_reg[2*idx+1 : 2*idx]; cmp_b = B_reg[2*idx+1 : 2*idx].
  - Each edge: accumulator <= accumulator & cmp_eq.
  - If cmp_eq = 0 and EARLY_EXIT = 1: go to DONE and set eq <= 0.
  - Else if idx = NSLICE-1: go to DONE and set eq <= accumulator & cmp_eq.
  - Otherwise: idx <= idx + 1 and stay in RUN.
- DONE: done = 1 for exactly this cycle, then unconditionally return to IDLE.
- Outside RUN: cmp_a and cmp_b = 2'b00.
- Verdict source: the controller derives equality only from cmp_eq. It never compares the operands directly.
- Latency: start sampled at edge k gives RUN for cycles k+1 .. k+m, where m = index of the first mismatching slice + 1 (EARLY_EXIT = 1), otherwise m = NSLICE. done is high in cycle k+m+1.
- eq hold: eq is updated only on DONE entry. It holds its value through IDLE and through the next RUN until the next DONE entry.
- start while in RUN or DONE is ignored; it is not queued.
- a and b changes after acceptance have no effect on the operation in flight.
- Throughput: start held constantly high accepts a new compare every m+2 cycles.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all reset values. The verdict is discarded and no done pulse is produced.
- Index counter width: clog2(NSLICE), minimum 1 bit. For NSLICE = 1 the first RUN cycle is also the last.

Test Plan (WIDTH=8, bench instantiates the 2-bit comparator on cmp_a/cmp_b/cmp_eq):
- Reset asserted asynchronously mid-cycle -> busy=0, done=0, eq=0, cmp_a=cmp_b=00 immediately, without waiting for a clock edge.
- a=8'hA5, b=8'hA5, one-cycle start -> busy high 4 cycles; cmp_a sequence 01,01,10,10; done pulse in cycle 5; eq=1 held afterwards.
- a=8'hA5, b=8'hA4:
  - EARLY_EXIT=1 -> one RUN cycle, done in cycle 2, eq=0.
  - EARLY_EXIT=0 -> four RUN cycles, done in cycle 5, eq=0.
- a=8'h00, b=8'hC0 (mismatch only in slice 3) -> 4 RUN cycles, done in cycle 5, eq=0; previous eq=1 retained until that edge.
- Extra start pulses during RUN plus a/b changed to 8'hFF/8'h00 mid-RUN -> ignored; verdict reflects latched operands; start held high -> accepts every m+2 cycles.
- reset pulsed in the 2nd RUN cycle -> IDLE, no done pulse, eq=0; a following start with a=b=8'h3C -> done in cycle 5, eq=1.
